hypipe_port_arbiter: RTL and testbench

Parametrised N-port ingress merger between the per-port `soc_runtime` packet outputs and the `HyPipe_Top` parser input. It replaces the single-port direct connection. Each port gets a store-and-forward FIFO with commit/rollback so that only complete packets are forwarded. A packet-granular round-robin arbiter then serialises the committed packets onto one 134b stream with ready backpressure, a source-port tag and per-port drop statistics.

---
 rtl/hypipe_pkg.sv | 39 +++
 rtl/hypipe_port_fifo.sv | 149 ++++++++++++++
 rtl/hypipe_port_arbiter.sv | 136 +++++++++++++
 tb/tb_hypipe_port_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hypipe_pkg.sv
// Shared definitions for the HyPipe ingress path.
// Word layout: [133:132] packet tag, [131:128] valid nibble, [127:0] payload.
package hypipe_pkg;

    localparam int DATA_W = 134;

    localparam int TAG_HI = 133;
    localparam int TAG_LO = 132;
    localparam int VLD_HI = 131;
    localparam int VLD_LO = 128;
    localparam int PAY_HI = 127;
    localparam int PAY_LO = 0;

    localparam logic [1:0] TAG_BODY   = 2'b00;
    localparam logic [1:0] TAG_HEAD   = 2'b01;
    localparam logic [1:0] TAG_TAIL   = 2'b10;
    localparam logic [1:0] TAG_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WRITE,
        WR_DROP
    } wr_state_e;

    typedef enum logic {
        ARB_SCAN,
        ARB_XFER
    } arb_state_e;

    // Single-word packets count as both head and tail.
    function automatic logic tag_is_head(input logic [1:0] tag);
        return (tag == TAG_HEAD) || (tag == TAG_SINGLE);
    endfunction

    function automatic logic tag_is_tail(input logic [1:0] tag);
        return (tag == TAG_TAIL) || (tag == TAG_SINGLE);
    endfunction

endpackage

// File: rtl/hypipe_port_fifo.sv
// Per-port store-and-forward packet FIFO. Words are written speculatively
// and only become visible to the reader once the packet tail is committed;
// malformed or oversized packets are rolled back.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   wr_valid, wr_data   - ingress word strobe and word (no backpressure)
//   rd_en, rd_data      - pop strobe and committed head-of-queue word
//   empty               - no committed word available
//   drop_cnt, err_cnt   - saturating dropped-packet / malformed-word counts
//
// state    | meaning
// ---------+-----------------------------------------------------------
// WR_IDLE  | between packets, waiting for a head
// WR_WRITE | admitted packet in progress, words written past wr_commit
// WR_DROP  | discarding the rest of a rejected packet until its tail
module hypipe_port_fifo #(
    parameter int DATA_W        = hypipe_pkg::DATA_W,
    parameter int FIFO_DEPTH    = 128,
    parameter int MAX_PKT_WORDS = 97,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  err_cnt
);
    import hypipe_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    wr_state_e         state, state_n;
    logic [PW-1:0]     wr_ptr, wr_commit, rd_ptr;
    logic [PW-1:0]     wr_ptr_n, wr_commit_n;
    logic [PW-1:0]     used_wr, used_commit;
    logic [PW:0]       free_commit;
    logic [AW-1:0]     waddr;
    logic              we, drop_inc, err_inc, eval_head;
    logic              full, admit;
    logic [1:0]        wr_tag;
    logic              is_head, is_tail, is_body;

    assign wr_tag  = wr_data[TAG_HI:TAG_LO];
    assign is_head = tag_is_head(wr_tag);
    assign is_tail = tag_is_tail(wr_tag);
    assign is_body = (wr_tag == TAG_BODY);

    // Admission is always judged against the committed fill level, since a
    // head arriving mid-packet rolls the speculative words back first.
    assign used_wr     = wr_ptr - rd_ptr;
    assign used_commit = wr_commit - rd_ptr;
    assign free_commit = (PW+1)'(FIFO_DEPTH) - {1'b0, used_commit};
    assign admit       = free_commit >= (PW+1)'(MAX_PKT_WORDS);
    assign full        = used_wr == PW'(FIFO_DEPTH);

    assign empty   = (rd_ptr == wr_commit);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_comb begin
        state_n     = state;
        wr_ptr_n    = wr_ptr;
        wr_commit_n = wr_commit;
        we          = 1'b0;
        waddr       = wr_ptr[AW-1:0];
        drop_inc    = 1'b0;
        err_inc     = 1'b0;
        eval_head   = 1'b0;
        if (wr_valid) begin
            case (state)
                WR_IDLE: begin
                    if (is_head) eval_head = 1'b1;
                    else         err_inc   = 1'b1;
                end
                WR_WRITE: begin
                    if (is_head) begin
                        err_inc   = 1'b1;
                        eval_head = 1'b1;
                    end else if (full) begin
                        // Oversized packet: a tail here already ends it.
                        drop_inc = 1'b1;
                        wr_ptr_n = wr_commit;
                        state_n  = is_tail ? WR_IDLE : WR_DROP;
                    end else begin
                        we       = 1'b1;
                        wr_ptr_n = wr_ptr + PW'(1);
                        if (!is_body) begin
                            wr_commit_n = wr_ptr + PW'(1);
                            state_n     = WR_IDLE;
                        end
                    end
                end
                WR_DROP: begin
                    if (is_head)      eval_head = 1'b1;
                    else if (is_tail) state_n   = WR_IDLE;
                end
                default: state_n = WR_IDLE;
            endcase

            if (eval_head) begin
                if (admit) begin
                    we       = 1'b1;
                    waddr    = wr_commit[AW-1:0];
                    wr_ptr_n = wr_commit + PW'(1);
                    if (is_tail) begin
                        wr_commit_n = wr_commit + PW'(1);
                        state_n     = WR_IDLE;
                    end else begin
                        state_n = WR_WRITE;
                    end
                end else begin
                    drop_inc = 1'b1;
                    wr_ptr_n = wr_commit;
                    state_n  = is_tail ? WR_IDLE : WR_DROP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WR_IDLE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            rd_ptr    <= '0;
            drop_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_n;
            wr_ptr    <= wr_ptr_n;
            wr_commit <= wr_commit_n;
            if (rd_en && !empty) rd_ptr <= rd_ptr + PW'(1);
            if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
            if (err_inc && (err_cnt != '1))   err_cnt  <= err_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wr_data;
    end

endmodule

// File: rtl/hypipe_port_arbiter.sv
// N-port ingress merger: one packet FIFO per port feeding a packet-granular
// round-robin arbiter and a registered output stage with ready backpressure.
//
// Ports:
//   i_clk, i_rst              - clock, synchronous active-high reset
//   i_data_valid, i_data      - per-port ingress words, port k at [k*DATA_W +: DATA_W]
//   o_data_valid, o_data      - registered output word
//   o_port_id                 - source port of o_data
//   i_ready                   - downstream accept
//   o_drop_cnt, o_err_cnt     - per-port saturating counters, port k at [k*CNT_W +: CNT_W]
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARB_SCAN | no packet in flight; pick next port and pop its head
// ARB_XFER | streaming the granted port until its tail is popped
module hypipe_port_arbiter #(
    parameter int NUM_PORTS     = 2,
    parameter int DATA_W        = hypipe_pkg::DATA_W,
    parameter int FIFO_DEPTH    = 128,
    parameter int MAX_PKT_WORDS = 97,
    parameter int CNT_W         = 16,
    localparam int ID_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_PORTS-1:0]      i_data_valid,
    input  logic [NUM_PORTS*DATA_W-1:0] i_data,
    output logic                      o_data_valid,
    output logic [DATA_W-1:0]         o_data,
    output logic [ID_W-1:0]           o_port_id,
    input  logic                      i_ready,
    output logic [NUM_PORTS*CNT_W-1:0] o_drop_cnt,
    output logic [NUM_PORTS*CNT_W-1:0] o_err_cnt
);
    import hypipe_pkg::*;

    logic [NUM_PORTS-1:0] empty, rd_en;
    logic [DATA_W-1:0]    rd_data [NUM_PORTS];

    arb_state_e           state, state_n;
    logic [ID_W-1:0]      grant, grant_n, last_grant, last_grant_n;
    logic [ID_W-1:0]      scan_port, sel_port;
    logic                 scan_hit, pop, pop_tail, can_load;
    logic [DATA_W-1:0]    pop_data;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        hypipe_port_fifo #(
            .DATA_W        (DATA_W),
            .FIFO_DEPTH    (FIFO_DEPTH),
            .MAX_PKT_WORDS (MAX_PKT_WORDS),
            .CNT_W         (CNT_W)
        ) u_fifo (
            .clk      (i_clk),
            .rst      (i_rst),
            .wr_valid (i_data_valid[k]),
            .wr_data  (i_data[k*DATA_W +: DATA_W]),
            .rd_en    (rd_en[k]),
            .rd_data  (rd_data[k]),
            .empty    (empty[k]),
            .drop_cnt (o_drop_cnt[k*CNT_W +: CNT_W]),
            .err_cnt  (o_err_cnt[k*CNT_W +: CNT_W])
        );
    end

    // Round-robin scan starting one past the last port that finished a packet.
    always_comb begin
        int         idx_int;
        logic [ID_W-1:0] idx;
        idx_int   = 0;
        idx       = '0;
        scan_hit  = 1'b0;
        scan_port = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            idx_int = int'(last_grant) + i;
            if (idx_int >= NUM_PORTS) idx_int = idx_int - NUM_PORTS;
            idx = ID_W'(idx_int);
            if (!scan_hit && !empty[idx]) begin
                scan_hit  = 1'b1;
                scan_port = idx;
            end
        end
    end

    assign can_load = !o_data_valid || i_ready;

    // The head is popped in the same cycle the grant is made, so a packet's
    // tail transfer and the next grant overlap without a bubble.
    always_comb begin
        state_n      = state;
        grant_n      = grant;
        last_grant_n = last_grant;
        rd_en        = '0;
        if (state == ARB_SCAN) begin
            sel_port = scan_port;
            pop      = can_load && scan_hit;
        end else begin
            sel_port = grant;
            pop      = can_load && !empty[grant];
        end
        pop_data = rd_data[sel_port];
        pop_tail = tag_is_tail(pop_data[TAG_HI:TAG_LO]);
        if (pop) begin
            rd_en[sel_port] = 1'b1;
            grant_n         = sel_port;
            if (pop_tail) begin
                last_grant_n = sel_port;
                state_n      = ARB_SCAN;
            end else begin
                state_n = ARB_XFER;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ARB_SCAN;
            grant        <= '0;
            last_grant   <= ID_W'(NUM_PORTS - 1);
            o_data_valid <= 1'b0;
            o_data       <= '0;
            o_port_id    <= '0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            if (can_load) begin
                o_data_valid <= pop;
                if (pop) begin
                    o_data    <= pop_data;
                    o_port_id <= sel_port;
                end
            end
        end
    end

endmodule

// File: tb/tb_hypipe_port_arbiter.sv
module tb_hypipe_port_arbiter;
    import hypipe_pkg::*;

    localparam int NP   = 2;
    localparam int DW   = 134;
    localparam int CW   = 16;
    localparam int ID_W = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     dv;
    logic [NP*DW-1:0]  din;
    logic              ov;
    logic [DW-1:0]     od;
    logic [ID_W-1:0]   oid;
    logic              rdy;
    logic [NP*CW-1:0]  dcnt, ecnt;

    always #5 clk = ~clk;

    hypipe_port_arbiter #(
        .NUM_PORTS(NP), .DATA_W(DW), .FIFO_DEPTH(128), .MAX_PKT_WORDS(97), .CNT_W(CW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_data_valid(dv), .i_data(din),
        .o_data_valid(ov), .o_data(od), .o_port_id(oid), .i_ready(rdy),
        .o_drop_cnt(dcnt), .o_err_cnt(ecnt)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW:0]   rx_q[$];
    logic [DW:0]   exp_q[$];
    logic [DW-1:0] pkt_words[$];

    always @(negedge clk) begin
        if (!rst && ov && rdy) rx_q.push_back({oid, od});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] make_word(input logic [1:0] tag);
        logic [DW-1:0] w;
        w = '0;
        w[TAG_HI:TAG_LO] = tag;
        w[VLD_HI:VLD_LO] = 4'($urandom);
        w[PAY_HI:PAY_LO] = {$urandom, $urandom, $urandom, $urandom};
        return w;
    endfunction

    task automatic send_word(input int port, input logic [DW-1:0] w);
        din[port*DW +: DW] = w;
        dv[port] = 1'b1;
        tick();
        dv[port] = 1'b0;
    endtask

    task automatic send_pkt(input int port, input int n);
        logic [1:0] tag;
        pkt_words.delete();
        for (int i = 0; i < n; i++) begin
            if (n == 1)          tag = TAG_SINGLE;
            else if (i == 0)     tag = TAG_HEAD;
            else if (i == n - 1) tag = TAG_TAIL;
            else                 tag = TAG_BODY;
            pkt_words.push_back(make_word(tag));
        end
        for (int i = 0; i < n; i++) send_word(port, pkt_words[i]);
    endtask

    task automatic push_exp(input int port, input logic [DW-1:0] words[$]);
        foreach (words[i]) exp_q.push_back({ID_W'(port), words[i]});
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int cyc = 0;
        while (rx_q.size() < n && cyc < budget) begin
            tick();
            cyc++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1; dv = '0; din = '0; rdy = 1'b0;
        repeat (3) tick();
        checks++;
        if (ov !== 1'b0 || od !== '0 || oid !== '0) begin
            failures++;
            $display("FAIL reset_out valid=%b data=%h id=%0d exp 0/0/0", ov, od, oid);
        end
        checks++;
        if (dcnt !== '0 || ecnt !== '0) begin
            failures++;
            $display("FAIL reset_cnt drop=%h err=%h exp 0", dcnt, ecnt);
        end
        rst = 1'b0;
        tick();
        exp_q.delete(); rx_q.delete();
    endtask

    task automatic test_single_packet();
        logic [DW:0] e, r;
        bit ok;
        rdy = 1'b1;
        send_pkt(0, 4);
        push_exp(0, pkt_words);
        checks++;
        if (ov !== 1'b0) begin
            failures++; $display("FAIL single_lat_t1 valid=%b exp 0", ov);
        end
        tick();
        checks++;
        if (ov !== 1'b1 || od !== pkt_words[0] || oid !== 1'b0) begin
            failures++;
            $display("FAIL single_lat_t2 valid=%b id=%0d data=%h exp 1/0/%h", ov, oid, od, pkt_words[0]);
        end
        wait_rx(4, 20, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL single_timeout got=%0d exp 4", rx_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
            if (r !== e) begin failures++; $display("FAIL single_data got=%h exp=%h", r, e); end
        end
        repeat (5) tick();
        checks++;
        if (rx_q.size() != 0) begin failures++; $display("FAIL single_extra got=%0d exp 0", rx_q.size()); end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] a[$], b[$], c[$], d[$];
        logic [DW:0] e, r;
        bit ok;
        rdy = 1'b0;
        send_pkt(0, 3); a = pkt_words;
        send_pkt(0, 3); b = pkt_words;
        send_pkt(1, 3); c = pkt_words;
        send_pkt(1, 3); d = pkt_words;
        push_exp(0, a); push_exp(1, c); push_exp(0, b); push_exp(1, d);
        repeat (2) tick();
        rdy = 1'b1;
        wait_rx(12, 60, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rr_timeout got=%0d exp 12", rx_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
            if (r !== e) begin failures++; $display("FAIL rr_order got=%h exp=%h", r, e); end
        end
        repeat (5) tick();
        checks++;
        if (rx_q.size() != 0) begin failures++; $display("FAIL rr_extra got=%0d exp 0", rx_q.size()); end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [DW:0] e, r;
        logic [DW-1:0] prev_d;
        logic [ID_W-1:0] prev_id;
        logic prev_v, prev_r;
        int cyc = 0;
        rdy = 1'b0;
        send_pkt(1, 10);
        push_exp(1, pkt_words);
        tick();
        while (rx_q.size() < 10 && cyc < 60) begin
            rdy = ~rdy;
            prev_v = ov; prev_d = od; prev_id = oid; prev_r = rdy;
            tick();
            cyc++;
            if (prev_v && !prev_r) begin
                checks++;
                if (ov !== 1'b1 || od !== prev_d || oid !== prev_id) begin
                    failures++;
                    $display("FAIL bp_stall valid=%b data=%h exp held %h", ov, od, prev_d);
                end
            end
        end
        rdy = 1'b1;
        checks++;
        if (rx_q.size() != 10) begin failures++; $display("FAIL bp_count got=%0d exp 10", rx_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
            if (r !== e) begin failures++; $display("FAIL bp_data got=%h exp=%h", r, e); end
        end
        repeat (3) tick();
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_admission_drop();
        logic [DW:0] e, r;
        bit ok;
        rdy = 1'b0;
        send_pkt(0, 40);
        push_exp(0, pkt_words);
        repeat (2) tick();
        send_pkt(0, 3);
        checks++;
        if (dcnt[CW-1:0] !== 16'd1 || dcnt[2*CW-1:CW] !== 16'd0) begin
            failures++; $display("FAIL adm_drop_cnt got=%h exp p0=1 p1=0", dcnt);
        end
        checks++;
        if (ecnt !== '0) begin failures++; $display("FAIL adm_err_cnt got=%h exp 0", ecnt); end
        rdy = 1'b1;
        wait_rx(40, 100, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL adm_timeout got=%0d exp 40", rx_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
            if (r !== e) begin failures++; $display("FAIL adm_data got=%h exp=%h", r, e); end
        end
        repeat (6) tick();
        checks++;
        if (rx_q.size() != 0) begin failures++; $display("FAIL adm_extra got=%0d exp 0", rx_q.size()); end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_malformed_head();
        logic [DW-1:0] w[5];
        logic [DW-1:0] good[$];
        logic [DW:0] e, r;
        bit ok;
        rdy = 1'b1;
        w[0] = make_word(TAG_HEAD); w[1] = make_word(TAG_BODY);
        w[2] = make_word(TAG_HEAD); w[3] = make_word(TAG_BODY);
        w[4] = make_word(TAG_TAIL);
        good.push_back(w[2]); good.push_back(w[3]); good.push_back(w[4]);
        push_exp(1, good);
        for (int i = 0; i < 5; i++) send_word(1, w[i]);
        checks++;
        if (ecnt[2*CW-1:CW] !== 16'd1 || dcnt[2*CW-1:CW] !== 16'd0) begin
            failures++; $display("FAIL mal_cnt err=%h drop=%h exp err1=1 drop1=0", ecnt, dcnt);
        end
        wait_rx(3, 20, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mal_timeout got=%0d exp 3", rx_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
            if (r !== e) begin failures++; $display("FAIL mal_data got=%h exp=%h", r, e); end
        end
        repeat (5) tick();
        checks++;
        if (rx_q.size() != 0) begin failures++; $display("FAIL mal_extra got=%0d exp 0", rx_q.size()); end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_single_word();
        logic [DW:0] e, r;
        bit ok;
        rdy = 1'b1;
        send_pkt(0, 1);
        push_exp(0, pkt_words);
        send_word(0, make_word(TAG_BODY));
        checks++;
        if (ecnt[CW-1:0] !== 16'd1) begin
            failures++; $display("FAIL orphan_err got=%h exp 1", ecnt[CW-1:0]);
        end
        wait_rx(1, 20, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL sw_timeout got=%0d exp 1", rx_q.size()); end
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
            if (r !== e) begin failures++; $display("FAIL sw_data got=%h exp=%h", r, e); end
        end
        repeat (5) tick();
        checks++;
        if (rx_q.size() != 0) begin failures++; $display("FAIL sw_extra got=%0d exp 0", rx_q.size()); end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] p0[$];
        logic [DW:0] e, r;
        int cyc = 0;
        bit saw_valid = 1'b0;
        rdy = 1'b0;
        send_pkt(0, 6); p0 = pkt_words;
        exp_q.push_back({1'b0, p0[0]});
        exp_q.push_back({1'b0, p0[1]});
        send_pkt(1, 3);
        rdy = 1'b1;
        while (rx_q.size() < 2 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (ov !== 1'b1 || od !== p0[2]) begin
            failures++; $display("FAIL rst_third valid=%b data=%h exp 1/%h", ov, od, p0[2]);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (ov !== 1'b0 || od !== '0 || oid !== '0) begin
            failures++; $display("FAIL rst_mid_out valid=%b data=%h id=%0d exp 0/0/0", ov, od, oid);
        end
        checks++;
        if (dcnt !== '0 || ecnt !== '0) begin
            failures++; $display("FAIL rst_mid_cnt drop=%h err=%h exp 0", dcnt, ecnt);
        end
        rst = 1'b0;
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            e = exp_q.pop_front(); r = rx_q.pop_front(); checks++;
            if (r !== e) begin failures++; $display("FAIL rst_pre_data got=%h exp=%h", r, e); end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL rst_pre_count missing=%0d exp 0", exp_q.size()); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ov) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid || rx_q.size() != 0) begin
            failures++; $display("FAIL rst_stale valid_seen=%b words=%0d exp 0/0", saw_valid, rx_q.size());
        end
        rx_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_backpressure();
        test_admission_drop();
        test_malformed_head();
        test_single_word();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
